led_face_scanner: RTL and testbench

- Parametrised row-scan driver for a common-row LED dot-matrix face display with green and red column planes.
- Scans one active-low row at a time and drives the column pattern for that row.
- Selects one of four built-in face images, with an optional blink mode.
- Sits between the game controller, which supplies `face_sel`, `blink_en` and `en`, and the matrix pins.

---
 rtl/led_face_scanner.sv | 109 ++++++++++
 tb/tb_led_face_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_face_scanner.sv
// Row-scan driver for a common-row LED dot-matrix face display.
// One active-low row is driven at a time, with green/red column patterns
// taken from one of four built-in face images. Blinking is optional.
module led_face_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      face_sel,
    input  logic            blink_en,
    output logic [ROWS-1:0] hang,
    output logic [COLS-1:0] gre,
    output logic [COLS-1:0] red,
    output logic            frame_done
);
    localparam int RW = $clog2(ROWS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(2 * BLINK_FRAMES);

    localparam logic [1:0] FACE_LAUGH   = 2'd0;
    localparam logic [1:0] FACE_CRY     = 2'd1;
    localparam logic [1:0] FACE_NEUTRAL = 2'd2;
    localparam logic [1:0] FACE_BLANK   = 2'd3;

    // div/row point at the slot that the next enabled edge puts on the pins
    logic [DW-1:0] div;
    logic [RW-1:0] row;
    logic [FW-1:0] frm;
    logic [1:0]    face;

    logic            row_start, last_div, last_row, last_frm, blink_off;
    logic [1:0]      face_now;
    logic [7:0]      pat;
    logic [ROWS-1:0] onehot;

    // Column pattern of one image row; rows beyond the 8-row image are dark
    function automatic logic [7:0] img_row(input logic [1:0] f, input logic [RW-1:0] r);
        logic [7:0] p;
        p = 8'h00;
        case (int'(r))
            1, 2, 3: p = 8'h66;
            5:       p = (f == FACE_LAUGH) ? 8'h42 : (f == FACE_CRY) ? 8'h18 : 8'h00;
            6:       p = (f == FACE_NEUTRAL) ? 8'h7E : 8'h24;
            7:       p = (f == FACE_LAUGH) ? 8'h18 : (f == FACE_CRY) ? 8'h42 : 8'h00;
            default: p = 8'h00;
        endcase
        if (f == FACE_BLANK) p = 8'h00;
        return p;
    endfunction

    // Decode the next slot: face latch point, wrap points, blink window
    always_comb begin
        row_start = (row == '0) && (div == '0);
        last_div  = (div == DW'(SCAN_DIV - 1));
        last_row  = (row == RW'(ROWS - 1));
        last_frm  = (frm == FW'(2 * BLINK_FRAMES - 1));
        blink_off = blink_en && (frm >= FW'(BLINK_FRAMES));
        face_now  = row_start ? face_sel : face;
        pat       = img_row(face_now, row);
        onehot    = {{(ROWS-1){1'b0}}, 1'b1} << (RW'(ROWS - 1) - row);
    end

    // Scan counters, face latch and registered pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            row        <= '0;
            frm        <= '0;
            face       <= FACE_BLANK;
            hang       <= '1;
            gre        <= '0;
            red        <= '0;
            frame_done <= 1'b0;
        end else if (en) begin
            face       <= face_now;
            frame_done <= last_row && last_div;
            if (blink_off) begin
                hang <= '1;
                gre  <= '0;
                red  <= '0;
            end else begin
                hang <= ~onehot;
                gre  <= (face_now == FACE_LAUGH || face_now == FACE_NEUTRAL) ? COLS'(pat) : '0;
                red  <= (face_now == FACE_CRY   || face_now == FACE_NEUTRAL) ? COLS'(pat) : '0;
            end
            if (last_div) begin
                div <= '0;
                if (last_row) begin
                    row <= '0;
                    frm <= last_frm ? '0 : frm + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end else begin
            // Blank while disabled; counters and latched face hold
            hang       <= '1;
            gre        <= '0;
            red        <= '0;
            frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_face_scanner.sv
// Bench for led_face_scanner: two configurations driven together and checked
// every cycle against a position-arithmetic model, plus literal spot checks.
module tb_led_face_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, blink_en;
    logic [1:0] fs0, fs1;

    logic [7:0]  h0, g0, r0;
    logic        fd0;
    logic [9:0]  h1;
    logic [11:0] g1, r1;
    logic        fd1;

    led_face_scanner #(.ROWS(8), .COLS(8), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut0 (
        .clk(clk), .rst(rst), .en(en), .face_sel(fs0), .blink_en(blink_en),
        .hang(h0), .gre(g0), .red(r0), .frame_done(fd0));

    led_face_scanner #(.ROWS(10), .COLS(12), .SCAN_DIV(1), .BLINK_FRAMES(3)) dut1 (
        .clk(clk), .rst(rst), .en(en), .face_sel(fs1), .blink_en(blink_en),
        .hang(h1), .gre(g1), .red(r1), .frame_done(fd1));

    int pass = 0;
    int total = 0;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        else pass++;
    endtask

    // ---------------- behavioural model ----------------
    // t = number of enabled edges since reset; everything follows from it.
    typedef struct {
        int          t;
        int          face;
        logic [15:0] h, g, r;
        logic        fd;
    } mst;

    function automatic logic [7:0] img(input int f, input int rw);
        logic [7:0] lau [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18};
        logic [7:0] cry [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42};
        logic [7:0] neu [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h7E, 8'h00};
        if (rw >= 8) return 8'h00;
        case (f)
            0:       return lau[rw];
            1:       return cry[rw];
            2:       return neu[rw];
            default: return 8'h00;
        endcase
    endfunction

    function automatic mst mreset(input int R);
        mst n;
        n.t = 0; n.face = 3;
        n.h = 16'((1 << R) - 1); n.g = '0; n.r = '0; n.fd = 1'b0;
        return n;
    endfunction

    function automatic mst mstep(input mst s, input int R, input int D, input int BF,
                                 input logic e, input logic b, input logic [1:0] fs);
        mst n;
        int pos, rw, frm;
        logic [7:0] p;
        n = s;
        n.h = 16'((1 << R) - 1); n.g = '0; n.r = '0; n.fd = 1'b0;
        if (e) begin
            pos = s.t % (R * D);
            rw  = pos / D;
            frm = (s.t / (R * D)) % (2 * BF);
            if (pos == 0) n.face = int'(fs);
            n.fd = (pos == R * D - 1);
            if (!(b && frm >= BF)) begin
                n.h = 16'(((1 << R) - 1) & ~(1 << (R - 1 - rw)));
                p = img(n.face, rw);
                if (n.face == 0 || n.face == 2) n.g = 16'(p);
                if (n.face == 1 || n.face == 2) n.r = 16'(p);
            end
            n.t = s.t + 1;
        end
        return n;
    endfunction

    mst m0, m1;

    // Model advances on the same edges as the DUTs, including async reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= mreset(8);
            m1 <= mreset(10);
        end else begin
            m0 <= mstep(m0, 8, 4, 2, en, blink_en, fs0);
            m1 <= mstep(m1, 10, 1, 3, en, blink_en, fs1);
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (total > 0) begin
            chk("hang0", 16'(h0), m0.h);
            chk("gre0",  16'(g0), m0.g);
            chk("red0",  16'(r0), m0.r);
            chk("fd0",   16'(fd0), 16'(m0.fd));
            chk("hang1", 16'(h1), m1.h);
            chk("gre1",  16'(g1), m1.g);
            chk("red1",  16'(r1), m1.r);
            chk("fd1",   16'(fd1), 16'(m1.fd));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [7:0] hx [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] lg [8] = '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18};

    initial begin
        rst = 1'b0; en = 1'b0; blink_en = 1'b0; fs0 = 2'd0; fs1 = 2'd2;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hang0", 16'(h0), 16'h00FF);
        chk("rst_gre0", 16'(g0), 16'h0);
        chk("rst_fd0", 16'(fd0), 16'h0);
        chk("rst_hang1", 16'(h1), 16'h03FF);
        rst = 1'b0; en = 1'b1;

        // First frame: laughing face, 4 cycles per row
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("f0_hang", 16'(h0), 16'(hx[(k-1)/4]));
            chk("f0_gre",  16'(g0), 16'(lg[(k-1)/4]));
            chk("f0_red",  16'(r0), 16'h0);
            chk("f0_fd",   16'(fd0), (k == 32) ? 16'h1 : 16'h0);
            if (k == 7) begin
                chk("wide_row6_gre", 16'(g1), 16'h07E);
                chk("wide_row6_red", 16'(r1), 16'h07E);
            end
            if (k == 9) begin
                chk("wide_row8_hang", 16'(h1), 16'h03FD);
                chk("wide_row8_gre", 16'(g1), 16'h0);
            end
            if (k == 10) chk("wide_row9_hang", 16'(h1), 16'h03FE);
        end

        // Frame 1 latches crying; mid-frame switch must not show until frame 2
        fs0 = 2'd1;
        tick(14);                       // edge 46, row 3
        fs0 = 2'd0;
        tick(7);                        // edge 53, row 5
        chk("cry_row5_red", 16'(r0), 16'h18);
        chk("cry_row5_gre", 16'(g0), 16'h0);
        tick(11);                       // edge 64
        chk("cry_fd", 16'(fd0), 16'h1);
        tick(21);                       // edge 85, frame 2 row 5
        chk("lau_row5_gre", 16'(g0), 16'h42);
        chk("lau_row5_red", 16'(r0), 16'h0);

        // Blink: frame 3 dark, frame 4 shown again
        tick(11);                       // edge 96
        blink_en = 1'b1;
        tick(4);                        // edge 100, frame 3 row 0
        chk("blink_hang", 16'(h0), 16'h00FF);
        tick(28);                       // edge 128
        chk("blink_fd", 16'(fd0), 16'h1);
        chk("blink_hang_end", 16'(h0), 16'h00FF);
        tick(21);                       // edge 149, frame 4 row 5
        chk("blink_back_gre", 16'(g0), 16'h42);
        chk("blink_back_hang", 16'(h0), 16'h00FB);
        blink_en = 1'b0;

        // Pause during the second cycle of row 2
        tick(21);                       // edge 170
        en = 1'b0;
        tick();
        chk("pause_hang", 16'(h0), 16'h00FF);
        chk("pause_fd", 16'(fd0), 16'h0);
        tick(9);
        en = 1'b1;
        tick();
        chk("resume_a", 16'(h0), 16'h00DF);
        tick();
        chk("resume_b", 16'(h0), 16'h00DF);
        tick();
        chk("resume_row3", 16'(h0), 16'h00EF);

        // Async reset between edges
        tick(9);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hang0", 16'(h0), 16'h00FF);
        chk("arst_hang1", 16'(h1), 16'h03FF);
        chk("arst_gre0", 16'(g0), 16'h0);
        @(negedge clk);
        fs0 = 2'd1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_row0", 16'(h0), 16'h007F);
        tick(20);
        chk("arst_cry_row5", 16'(r0), 16'h18);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 7) == 0) fs0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) fs1 = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
